// File: rtl/tnn_neuron_seq.sv
// tnn_neuron_seq: sequential threshold neuron for the TNN classifier datapath.
// Accumulates one signed-weighted input channel per cycle into a saturating
// accumulator, then compares the sum against a runtime threshold.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     input-sample handshake (in_ready high only in IDLE)
//   in_data               NUM_IN channels of IN_W bits, channel 0 at the LSBs
//   sign_mask             bit k = 1 subtracts channel k, 0 adds it
//   thr                   signed decision threshold
//   out_valid/out_ready   result handshake (out_valid high only in DONE)
//   out_class             1 when out_sum >= thr (signed)
//   out_sum               signed saturated sum
//   out_sat               saturation happened at least once in this sample
module tnn_neuron_seq #(
  parameter int unsigned NUM_IN    = 5,
  parameter int unsigned IN_W      = 3,
  parameter int unsigned ACC_W     = 7,
  parameter int unsigned TRUNC_LSB = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_IN*IN_W-1:0]   in_data,
  input  logic [NUM_IN-1:0]        sign_mask,
  input  logic [ACC_W-1:0]         thr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_class,
  output logic [ACC_W-1:0]         out_sum,
  output logic                     out_sat
);

  localparam int unsigned IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e                   state_q, state_d;
  logic [NUM_IN*IN_W-1:0]   data_q, data_d;
  logic [NUM_IN-1:0]        mask_q, mask_d;
  logic [ACC_W-1:0]         thr_q, thr_d;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     sat_q, sat_d;
  logic [ACC_W-1:0]         out_sum_q, out_sum_d;
  logic                     out_class_q, out_class_d;
  logic                     out_sat_q, out_sat_d;

  // Single accumulation step for the channel selected by idx_q.
  logic [IN_W-1:0]  trunc_mask;
  logic [IN_W-1:0]  ch;
  logic             ch_neg;
  logic [ACC_W:0]   op_ext;
  logic [ACC_W:0]   acc_ext;
  logic [ACC_W:0]   raw_sum;
  logic [ACC_W-1:0] step_sum;
  logic             step_clamp;

  assign trunc_mask = {IN_W{1'b1}} << TRUNC_LSB;

  always_comb begin
    ch     = '0;
    ch_neg = 1'b0;
    for (int k = 0; k < int'(NUM_IN); k++) begin
      if (idx_q == IDX_W'(k)) begin
        ch     = data_q[k*IN_W +: IN_W];
        ch_neg = mask_q[k];
      end
    end
    op_ext  = {{(ACC_W + 1 - IN_W){1'b0}}, ch & trunc_mask};
    acc_ext = {acc_q[ACC_W-1], acc_q};
    raw_sum = ch_neg ? (acc_ext - op_ext) : (acc_ext + op_ext);
    // One extra bit is enough headroom: the top two bits differ only on overflow.
    step_clamp = raw_sum[ACC_W] ^ raw_sum[ACC_W-1];
    if (!step_clamp) begin
      step_sum = raw_sum[ACC_W-1:0];
    end else if (raw_sum[ACC_W]) begin
      step_sum = {1'b1, {(ACC_W - 1){1'b0}}};
    end else begin
      step_sum = {1'b0, {(ACC_W - 1){1'b1}}};
    end
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    mask_d      = mask_q;
    thr_d       = thr_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    sat_d       = sat_q;
    out_sum_d   = out_sum_q;
    out_class_d = out_class_q;
    out_sat_d   = out_sat_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          data_d  = in_data;
          mask_d  = sign_mask;
          thr_d   = thr;
          acc_d   = '0;
          idx_d   = '0;
          sat_d   = 1'b0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        acc_d = step_sum;
        sat_d = sat_q | step_clamp;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(NUM_IN - 1)) begin
          idx_d       = '0;
          out_sum_d   = step_sum;
          out_class_d = $signed(step_sum) >= $signed(thr_q);
          out_sat_d   = sat_q | step_clamp;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      data_q      <= '0;
      mask_q      <= '0;
      thr_q       <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      sat_q       <= 1'b0;
      out_sum_q   <= '0;
      out_class_q <= 1'b0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      thr_q       <= thr_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      sat_q       <= sat_d;
      out_sum_q   <= out_sum_d;
      out_class_q <= out_class_d;
      out_sat_q   <= out_sat_d;
    end
  end

  // Handshake flags depend on state only, never on in_valid/out_ready.
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_sum   = out_sum_q;
  assign out_class = out_class_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_tnn_neuron_seq.sv
// Bench for tnn_neuron_seq: three instances (defaults, TRUNC_LSB=1, ACC_W=5)
// checked against an integer reference model of the neuron.
module tb_tnn_neuron_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  in_valid_v = '0;
  logic [2:0]  out_ready_v = '0;
  logic [2:0]  in_ready_v;
  logic [2:0]  out_valid_v;
  logic [2:0]  out_class_v;
  logic [2:0]  out_sat_v;
  logic [14:0] in_data = '0;
  logic [4:0]  sign_mask = '0;
  logic [6:0]  thr_a = '0;
  logic [4:0]  thr_b = '0;
  logic [6:0]  out_sum0, out_sum1;
  logic [4:0]  out_sum2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tnn_neuron_seq u_def (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_data(in_data), .sign_mask(sign_mask), .thr(thr_a),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .out_class(out_class_v[0]),
    .out_sum(out_sum0), .out_sat(out_sat_v[0])
  );

  tnn_neuron_seq #(.TRUNC_LSB(1)) u_trunc (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_data(in_data), .sign_mask(sign_mask), .thr(thr_a),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .out_class(out_class_v[1]),
    .out_sum(out_sum1), .out_sat(out_sat_v[1])
  );

  tnn_neuron_seq #(.ACC_W(5)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_data(in_data), .sign_mask(sign_mask), .thr(thr_b),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .out_class(out_class_v[2]),
    .out_sum(out_sum2), .out_sat(out_sat_v[2])
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int get_sum(input int sel);
    case (sel)
      0:       return int'($signed(out_sum0));
      1:       return int'($signed(out_sum1));
      default: return int'($signed(out_sum2));
    endcase
  endfunction

  function automatic int trunc_of(input int sel);
    return (sel == 1) ? 1 : 0;
  endfunction

  function automatic int accw_of(input int sel);
    return (sel == 2) ? 5 : 7;
  endfunction

  // Reference: walk channels in order, clamp after every term.
  task automatic model(input logic [14:0] d, input logic [4:0] m, input int t,
                       input int sel, output int s, output int cls, output int sat);
    int lo, hi, op, tr;
    lo  = -(1 << (accw_of(sel) - 1));
    hi  = (1 << (accw_of(sel) - 1)) - 1;
    tr  = trunc_of(sel);
    s   = 0;
    sat = 0;
    for (int k = 0; k < 5; k++) begin
      op = int'((d >> (3 * k)) & 15'd7);
      op = (op >> tr) << tr;
      s  = m[k] ? s - op : s + op;
      if (s > hi) begin s = hi; sat = 1; end
      if (s < lo) begin s = lo; sat = 1; end
    end
    cls = (s >= t) ? 1 : 0;
  endtask

  task automatic present(input int sel, input logic [14:0] d, input logic [4:0] m, input int t);
    in_data         = d;
    sign_mask       = m;
    thr_a           = 7'(t);
    thr_b           = 5'(t);
    in_valid_v[sel] = 1'b1;
  endtask

  // Accept on the next edge, then scramble inputs to prove they were latched.
  task automatic send(input int sel, input logic [14:0] d, input logic [4:0] m, input int t);
    present(sel, d, m, t);
    @(posedge clk);
    #1;
    in_valid_v = '0;
    in_data    = 15'($urandom);
    sign_mask  = 5'($urandom);
    thr_a      = 7'($urandom);
    thr_b      = 5'($urandom);
  endtask

  task automatic wait_out(input int sel, output int n);
    n = 0;
    while (!out_valid_v[sel] && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic check_result(input string tag, input int sel, input logic [14:0] d,
                              input logic [4:0] m, input int t);
    int s, cls, sat, n;
    model(d, m, t, sel, s, cls, sat);
    wait_out(sel, n);
    check({tag, " latency"}, n, 5);
    check({tag, " sum"}, get_sum(sel), s);
    check({tag, " class"}, out_class_v[sel], cls);
    check({tag, " sat"}, out_sat_v[sel], sat);
  endtask

  task automatic handoff(input string tag, input int sel);
    int s;
    s = get_sum(sel);
    out_ready_v[sel] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_v[sel] = 1'b0;
    check({tag, " valid drop"}, out_valid_v[sel], 0);
    check({tag, " ready back"}, in_ready_v[sel], 1);
    check({tag, " sum held"}, get_sum(sel), s);
  endtask

  task automatic run(input string tag, input int sel, input logic [14:0] d,
                     input logic [4:0] m, input int t);
    send(sel, d, m, t);
    check_result(tag, sel, d, m, t);
    handoff(tag, sel);
  endtask

  initial begin
    logic [14:0] d, d2;
    logic [4:0]  m, m2;
    int          t, t2, s1, n;

    // Reset state
    #2;
    for (int i = 0; i < 3; i++) begin
      check("rst in_ready", in_ready_v[i], 1);
      check("rst out_valid", out_valid_v[i], 0);
      check("rst out_class", out_class_v[i], 0);
      check("rst out_sat", out_sat_v[i], 0);
      check("rst out_sum", get_sum(i), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases
    run("basic add", 0, {5{3'd7}}, 5'b00000, 20);
    check("basic add sum35", get_sum(0), 35);
    run("signed mix", 0, {3'd1, 3'd1, 3'd1, 3'd7, 3'd7}, 5'b00011, 0);
    check("signed mix sum-11", get_sum(0), -11);
    run("trunc eq", 1, {5{3'd3}}, 5'b00000, 10);
    check("trunc eq class", out_class_v[1], 1);
    run("trunc gt", 1, {5{3'd3}}, 5'b00000, 11);
    check("trunc gt class", out_class_v[1], 0);
    run("sat pos", 2, {5{3'd7}}, 5'b00000, 0);
    check("sat pos sum15", get_sum(2), 15);
    run("sat neg", 2, {5{3'd7}}, 5'b11111, 0);
    check("sat neg sum-16", get_sum(2), -16);
    run("sat clear", 2, {12'd0, 3'd7}, 5'b00000, 0);
    check("sat clear flag", out_sat_v[2], 0);
    // Clamped intermediate: +7+7+7 clamps at 15, then -7 -7 gives 1 (not 7)
    run("sat midway", 2, {5{3'd7}}, 5'b11000, 0);
    check("sat midway sum1", get_sum(2), 1);

    // One-cycle out_valid with out_ready already high
    out_ready_v[0] = 1'b1;
    send(0, 15'h1234, 5'b01010, 3);
    wait_out(0, n);
    check("pulse latency", n, 5);
    @(posedge clk);
    #1;
    check("pulse one cycle", out_valid_v[0], 0);
    out_ready_v[0] = 1'b0;
    @(posedge clk);
    #1;

    // Back-pressure with a second sample held on in_valid
    d  = 15'($urandom); m  = 5'($urandom); t  = $urandom_range(0, 127) - 64;
    d2 = 15'($urandom); m2 = 5'($urandom); t2 = $urandom_range(0, 127) - 64;
    model(d, m, t, 0, s1, n, n);
    send(0, d, m, t);
    wait_out(0, n);
    check("bp latency", n, 5);
    present(0, d2, m2, t2);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp valid hold", out_valid_v[0], 1);
      check("bp in_ready low", in_ready_v[0], 0);
      check("bp sum hold", get_sum(0), s1);
    end
    out_ready_v[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_v[0] = 1'b0;
    check("bp no same-edge accept", in_ready_v[0], 1);
    @(posedge clk);
    #1;
    in_valid_v = '0;
    check("bp second accepted", in_ready_v[0], 0);
    check_result("bp second", 0, d2, m2, t2);
    handoff("bp second", 0);

    // Reset mid-operation
    send(0, {5{3'd7}}, 5'b00000, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst in_ready", in_ready_v[0], 1);
    check("midrst out_valid", out_valid_v[0], 0);
    check("midrst out_sum", get_sum(0), 0);
    check("midrst out_class", out_class_v[0], 0);
    check("midrst out_sat", out_sat_v[0], 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run("after rst", 0, {5{3'd1}}, 5'b00000, 5);
    check("after rst sum5", get_sum(0), 5);
    check("after rst class", out_class_v[0], 1);

    // Random samples on every instance
    for (int i = 0; i < 60; i++) begin
      int sel, aw;
      sel = i % 3;
      aw  = accw_of(sel);
      d   = 15'($urandom);
      m   = 5'($urandom);
      t   = $urandom_range(0, (1 << aw) - 1) - (1 << (aw - 1));
      run("random", sel, d, m, t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
